// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and hazard-controller state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

  // U-type and JAL carry no rs1; everything else reads it (or ignores a zero field harmlessly).
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
// Latency: count updates one cycle after inc; holds at all-ones.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, rst (sync, active-high), clear (sync clear), inc (count enable),
//        count[W-1:0] (registered value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use / branch-redirect / dmem-wait hazard sequencer for the 5-stage RV32I core.
// Latency: all control outputs are combinational from state + inputs (same cycle).
// Backpressure: dmem wait freezes PC and all pipeline registers until dmem_ready.
//
// Ports: clk, rst (sync, active-high); ID operands (id_opcode, id_rs1, id_rs2);
//        EX info (ex_memread, ex_rd, ex_taken); MEM handshake (mem_req, dmem_ready);
//        enables/flushes (pc_write, pc_redirect, ifid_write, ifid_flush, cu_stall,
//        cu_flush, pipe_hold); status (mem_timeout, stall_cnt, flush_cnt).
module hazard_sequencer
  import rv32i_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             cu_stall,
  output logic             cu_flush,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_VAL = WCNT_W'(TIMEOUT);

  hz_state_t         state_q, state_d;
  hz_state_t         ret_q, ret_d;
  logic [1:0]        dcnt_q, dcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;

  hz_state_t cur_state, eff_state;
  logic      mem_stall, load_use, stall_inc, flush_inc;

  assign mem_stall = mem_req & ~dmem_ready;
  assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                     ((uses_rs1(id_opcode) && (ex_rd == id_rs1)) ||
                      (uses_rs2(id_opcode) && (ex_rd == id_rs2)));

  // During reset the outputs behave as in RUN, whatever the register holds.
  assign cur_state = rst ? ST_RUN : state_q;
  // On a MEM_WAIT release cycle the interrupted state's rules apply.
  assign eff_state = (cur_state == ST_MEM_WAIT) ? ret_q : cur_state;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    pc_redirect = 1'b0;
    ifid_flush  = 1'b0;
    cu_stall    = 1'b0;
    cu_flush    = 1'b0;
    pipe_hold   = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    dcnt_d      = dcnt_q;
    wcnt_d      = '0;
    timeout_d   = timeout_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (mem_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      stall_inc  = 1'b1;
      if (cur_state != ST_MEM_WAIT) begin
        ret_d   = cur_state;
        state_d = ST_MEM_WAIT;
      end
      // Saturate at TIMEOUT so a long wait cannot wrap back below it.
      wcnt_d = (wcnt_q == TO_VAL) ? wcnt_q : wcnt_q + 1'b1;
      if (wcnt_d == TO_VAL) begin
        timeout_d = 1'b1;
      end
    end else begin
      state_d = eff_state;
      unique case (eff_state)
        ST_REDIRECT: begin
          // EX/ID only hold bubbles here, so taken/load-use are not looked at.
          ifid_flush = 1'b1;
          if (dcnt_q <= 2'd1) begin
            dcnt_d  = 2'd0;
            state_d = ST_RUN;
          end else begin
            dcnt_d = dcnt_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          if (ex_taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            cu_flush    = 1'b1;
            flush_inc   = 1'b1;
            if (IMEM_LAT > 0) begin
              state_d = ST_REDIRECT;
              dcnt_d  = 2'(IMEM_LAT);
            end
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            cu_stall   = 1'b1;
            stall_inc  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      dcnt_q    <= 2'd0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table driven each cycle,
// expected outputs and counter values queued at drive time, compared shortly after.
// Small parameters (TIMEOUT=4, CNT_W=4) make timeout and saturation reachable.
module tb_hazard_sequencer;

  localparam int CW = 4;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] IMM = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;

  // {pc_write, pc_redirect, ifid_write, ifid_flush, cu_stall, cu_flush, pipe_hold, mem_timeout}
  localparam logic [7:0] E_IDLE = 8'b1010_0000;
  localparam logic [7:0] E_TKN  = 8'b1111_0100;
  localparam logic [7:0] E_RDR  = 8'b1011_0000;
  localparam logic [7:0] E_LU   = 8'b0000_1000;
  localparam logic [7:0] E_MW   = 8'b0000_0010;
  localparam logic [7:0] E_MWT  = 8'b0000_0011;
  localparam logic [7:0] E_IDT  = 8'b1010_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic ex_memread = 1'b0, ex_taken = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_write, pc_redirect, ifid_write, ifid_flush, cu_stall, cu_flush, pipe_hold, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_sequencer #(.IMEM_LAT(1), .TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_taken(ex_taken),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_redirect(pc_redirect), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .cu_stall(cu_stall), .cu_flush(cu_flush),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic       r;
    logic [6:0] op;
    logic [4:0] rs1, rs2;
    logic       mr;
    logic [4:0] rd;
    logic       tk, mq, rdy;
    logic [7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0]    exp;
    logic [CW-1:0] scnt;
    logic [CW-1:0] fcnt;
    int            idx;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(logic r, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                             logic mr, logic [4:0] rd, logic tk, logic mq, logic rdy,
                             logic [7:0] exp);
    vec_t t;
    t.r = r; t.op = op; t.rs1 = rs1; t.rs2 = rs2; t.mr = mr; t.rd = rd;
    t.tk = tk; t.mq = mq; t.rdy = rdy; t.exp = exp;
    return t;
  endfunction

  // Monitor: compares each queued expectation 2 time units after the falling edge.
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0) begin
      sb_t e;
      logic [7:0] act;
      e = sb.pop_front();
      act = {pc_write, pc_redirect, ifid_write, ifid_flush, cu_stall, cu_flush, pipe_hold, mem_timeout};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL vec%0d outputs: got %b want %b", e.idx, act, e.exp);
      end
      checks++;
      if (stall_cnt !== e.scnt) begin
        errors++;
        $display("FAIL vec%0d stall_cnt: got %0d want %0d", e.idx, stall_cnt, e.scnt);
      end
      checks++;
      if (flush_cnt !== e.fcnt) begin
        errors++;
        $display("FAIL vec%0d flush_cnt: got %0d want %0d", e.idx, flush_cnt, e.fcnt);
      end
    end
  end

  initial begin
    logic [CW-1:0] m_s, m_f;
    sb_t e;

    // reset row and load-use detection
    tbl.push_back(v(1, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 0 reset
    tbl.push_back(v(0, R,   5, 1, 1, 5, 0, 0, 0, E_LU));     // 1 add x6,x5,x1 after lw x5
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 2 one cycle only
    tbl.push_back(v(0, ST,  2, 7, 1, 7, 0, 0, 0, E_LU));     // 3 rs2 match on store
    tbl.push_back(v(0, R,   0, 0, 1, 0, 0, 0, 0, E_IDLE));   // 4 rd=x0 never stalls
    tbl.push_back(v(0, LUI, 9, 9, 1, 9, 0, 0, 0, E_IDLE));   // 5 LUI reads no regs
    tbl.push_back(v(0, IMM, 1, 9, 1, 9, 0, 0, 0, E_IDLE));   // 6 I-type ignores rs2 field
    tbl.push_back(v(0, R,   9, 9, 0, 9, 0, 0, 0, E_IDLE));   // 7 not a load
    // redirect, IMEM_LAT=1
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 1, 0, 0, E_TKN));    // 8
    tbl.push_back(v(0, R,   5, 5, 1, 5, 1, 0, 0, E_RDR));    // 9 taken/load-use ignored
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 10 back in RUN
    // three wait cycles then release
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MW));     // 11
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MW));     // 12
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MW));     // 13
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 1, E_IDLE));   // 14 release
    // wait during REDIRECT
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 1, 0, 0, E_TKN));    // 15
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MW));     // 16 flush withheld
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MW));     // 17
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 1, E_RDR));    // 18 release, one flush
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 19 RUN
    // priority and release-cycle rules
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 1, 1, 0, E_MW));     // 20 stall beats taken
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 1, 1, 1, E_TKN));    // 21 taken on release
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_RDR));    // 22
    tbl.push_back(v(0, R,   3, 0, 1, 3, 0, 0, 0, E_LU));     // 23
    tbl.push_back(v(0, R,   3, 0, 1, 3, 0, 1, 0, E_MW));     // 24 stall beats load-use
    tbl.push_back(v(0, R,   3, 0, 1, 3, 0, 1, 1, E_LU));     // 25 load-use on release
    // timeout: wcnt reaches 4 after the 4th stall cycle; stall_cnt saturates at 15
    for (int i = 0; i < 4; i++) tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MW));  // 26-29
    for (int i = 0; i < 2; i++) tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 0, E_MWT)); // 30-31
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 1, 1, E_IDT));    // 32 sticky
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDT));    // 33
    tbl.push_back(v(1, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDT));    // 34 rst, flag clears at edge
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 35
    // reset in the middle of REDIRECT
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 1, 0, 0, E_TKN));    // 36
    tbl.push_back(v(1, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 37 RUN values while in reset
    tbl.push_back(v(0, IMM, 0, 0, 0, 0, 0, 0, 0, E_IDLE));   // 38 aborted to RUN

    repeat (2) @(negedge clk);

    m_s = '0;
    m_f = '0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst        = tbl[i].r;
      id_opcode  = tbl[i].op;
      id_rs1     = tbl[i].rs1;
      id_rs2     = tbl[i].rs2;
      ex_memread = tbl[i].mr;
      ex_rd      = tbl[i].rd;
      ex_taken   = tbl[i].tk;
      mem_req    = tbl[i].mq;
      dmem_ready = tbl[i].rdy;
      e.exp  = tbl[i].exp;
      e.scnt = m_s;
      e.fcnt = m_f;
      e.idx  = i;
      sb.push_back(e);
      // counter reference: value seen next cycle
      if (tbl[i].r) begin
        m_s = '0;
        m_f = '0;
      end else begin
        if ((tbl[i].exp[3] || tbl[i].exp[1]) && (m_s != '1)) m_s = m_s + 1'b1;
        if (tbl[i].exp[6] && (m_f != '1)) m_f = m_f + 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    #4;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
